// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic processing element.
package pe_pkg;

  localparam int DATA_W        = 16;
  localparam int ACC_W_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/pe_fifo.sv
// Synchronous show-ahead FIFO holding one operand stream of the PE.
// A write while full is dropped, even if a read happens in the same cycle.
module pe_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       cnt;
  logic              wr;
  logic              rd;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign wr    = we & ~full;
  assign rd    = re & ~empty;
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      case ({wr, rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/systolic_pe.sv
// One systolic matrix-multiply PE: FIFO-buffered A/B operands, max_cntr signed MACs,
// 16-bit result. Define PE_SATURATE_EN to clamp the result (else it wraps, sat stays 0).
module systolic_pe
  import pe_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = ACC_W_DEFAULT,
  parameter int FRAC_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              awe,
  input  logic              bwe,
  input  logic              ais,
  input  logic              bis,
  input  logic              start,
  input  logic [7:0]        max_cntr,
  output logic              aff,
  output logic              bff,
  output logic              se,
  output logic              fout,
  output logic              sat,
  output logic [DATA_W-1:0] s_out,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              start_next
);

  state_t                     state_p0;
  state_t                     state_nxt;
  logic signed [DATA_W-1:0]   a_head;
  logic signed [DATA_W-1:0]   b_head;
  logic                       a_empty;
  logic                       b_empty;
  logic                       pop;
  logic                       fire;
  logic signed [2*DATA_W-1:0] prod_p0;
  logic signed [ACC_W-1:0]    acc_p1;
  logic [7:0]                 cnt_p1;
  logic [DATA_W:0]            res_p1;

  // Returns {overflow, value} for the accumulator scaled down by FRAC_SHIFT.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] acc);
`ifdef PE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(DATA_W-1)));
    logic signed [ACC_W-1:0] r;
    r = acc >>> FRAC_SHIFT;
    if (r > SAT_MAX)      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (r < SAT_MIN) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                  return {1'b0, r[DATA_W-1:0]};
`else
    return {1'b0, DATA_W'(acc >>> FRAC_SHIFT)};
`endif
  endfunction

  pe_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo_a (
    .clk   (clk),
    .rst   (rst_n),
    .din   (a_in),
    .we    (awe),
    .re    (pop),
    .dout  (a_head),
    .full  (aff),
    .empty (a_empty)
  );

  pe_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo_b (
    .clk   (clk),
    .rst   (rst_n),
    .din   (b_in),
    .we    (bwe),
    .re    (pop),
    .dout  (b_head),
    .full  (bff),
    .empty (b_empty)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  // start overrides every state and blocks consumption in its own cycle.
  always_comb begin
    state_nxt = state_p0;
    pop       = 1'b0;
    fire      = 1'b0;
    case (state_p0)
      RUN: begin
        if (cnt_p1 == max_cntr) state_nxt = DONE;
        else                    pop = ~a_empty & ~b_empty & ~ais & ~bis;
      end
      DONE: begin
        fire      = 1'b1;
        state_nxt = IDLE;
      end
      default: ;
    endcase
    if (start) begin
      state_nxt = RUN;
      pop       = 1'b0;
      fire      = 1'b0;
    end
  end

  // p0 -> p1: multiply FIFO heads and accumulate
  assign prod_p0 = a_head * b_head;

  // p1 -> p2: scale and clamp the finished sum
  assign res_p1 = saturate(acc_p1);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc_p1     <= '0;
      cnt_p1     <= '0;
      a_out      <= '0;
      b_out      <= '0;
      s_out      <= '0;
      sat        <= 1'b0;
      se         <= 1'b0;
      fout       <= 1'b0;
      start_next <= 1'b0;
    end else begin
      start_next <= start;
      fout       <= pop;
      se         <= fire;
      if (start) begin
        acc_p1 <= '0;
        cnt_p1 <= '0;
        s_out  <= '0;
        sat    <= 1'b0;
      end else begin
        if (pop) begin
          acc_p1 <= acc_p1 + ACC_W'(prod_p0);
          cnt_p1 <= cnt_p1 + 8'd1;
          a_out  <= a_head;
          b_out  <= b_head;
        end
        if (fire) begin
          s_out <= res_p1[DATA_W-1:0];
          sat   <= res_p1[DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Scoreboard bench for systolic_pe: expected sums are queued at issue, popped on se.
module tb_systolic_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        awe = 1'b0, bwe = 1'b0, ais = 1'b0, bis = 1'b0, start = 1'b0;
  logic [7:0]  max_cntr = '0;
  logic        aff, bff, se, fout, sat, start_next;
  logic [15:0] s_out, a_out, b_out;

  typedef struct {
    logic [15:0] s;
    logic        sat;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   se_cnt = 0;
  int   fout_cnt = 0;
  int   last_fout_cyc = 0;
  int   last_se_cyc = 0;

`ifdef PE_SATURATE_EN
  localparam logic [15:0] EXP_BIG_S   = 16'h7FFF;
  localparam logic        EXP_BIG_SAT = 1'b1;
  localparam logic [15:0] EXP_NEG_S   = 16'h8000;
  localparam logic        EXP_NEG_SAT = 1'b1;
`else
  localparam logic [15:0] EXP_BIG_S   = 16'hE960;
  localparam logic        EXP_BIG_SAT = 1'b0;
  localparam logic [15:0] EXP_NEG_S   = 16'h40E0;
  localparam logic        EXP_NEG_SAT = 1'b0;
`endif

  systolic_pe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .awe        (awe),
    .bwe        (bwe),
    .ais        (ais),
    .bis        (bis),
    .start      (start),
    .max_cntr   (max_cntr),
    .aff        (aff),
    .bff        (bff),
    .se         (se),
    .fout       (fout),
    .sat        (sat),
    .s_out      (s_out),
    .a_out      (a_out),
    .b_out      (b_out),
    .start_next (start_next)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every se strobe must match the oldest queued expectation.
  initial begin
    logic se_prev;
    exp_t e;
    se_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (fout) begin
        fout_cnt++;
        last_fout_cyc = cyc;
      end
      if (se) begin
        se_cnt++;
        last_se_cyc = cyc;
        checks++;
        if (se_prev) begin
          failures++;
          $display("FAIL se_width: se high on consecutive cycles, required single-cycle pulse");
        end
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL se_unexpected: s_out=%h sat=%b with no result pending", s_out, sat);
        end else begin
          e = sbq.pop_front();
          if (s_out !== e.s || sat !== e.sat) begin
            failures++;
            $display("FAIL %s: s_out=%h sat=%b required s_out=%h sat=%b", e.name, s_out, sat, e.s, e.sat);
          end
        end
      end
      se_prev = se;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] b);
    awe = 1'b1; bwe = 1'b1; a_in = a; b_in = b;
    tick();
    awe = 1'b0; bwe = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    max_cntr = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_se(input int target, input string name);
    int n;
    n = 0;
    while (se_cnt < target && n < 80) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (se_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: se count %0d required %0d", name, se_cnt, target);
    end
  endtask

  initial begin
    int f0;
    int se0;

    // Reset state
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_aff", aff, 0);
    chk("rst_bff", bff, 0);
    chk("rst_s_out", s_out, 0);
    chk("rst_sat", sat, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_start_next", start_next, 0);

    // Four MACs, sum 125280 overflows 16 bits
    sbq.push_back('{EXP_BIG_S, EXP_BIG_SAT, "sum4_big"});
    f0 = fout_cnt;
    se0 = se_cnt;
    tick();
    pulse_start(8'd4);
    @(negedge clk);
    chk("start_next_hi", start_next, 1);
    tick();
    chk("start_next_lo", start_next, 0);
    wr(16'd100, 16'd200); tick();
    wr(16'd300, 16'd100); tick();
    wr(16'd255, 16'd256); tick();
    wr(16'd100, 16'd100); tick();
    wait_se(se0 + 1, "sum4_big");
    chk("fout_pulses", fout_cnt - f0, 4);
    chk("a_out_last", a_out, 100);
    chk("b_out_last", b_out, 100);
    chk("se_latency", last_se_cyc - last_fout_cyc, 2);

    // Two MACs, small negative result
    sbq.push_back('{16'hFFEE, 1'b0, "sum2_neg18"});
    se0 = se_cnt;
    tick();
    pulse_start(8'd2);
    wr(16'd3, 16'd4);
    wr(16'hFFFB, 16'd6);
    wait_se(se0 + 1, "sum2_neg18");

    // Two MACs, -180000 underflows 16 bits
    sbq.push_back('{EXP_NEG_S, EXP_NEG_SAT, "sum2_min"});
    se0 = se_cnt;
    tick();
    pulse_start(8'd2);
    wr(16'hFED4, 16'd300);
    wr(16'hFED4, 16'd300);
    wait_se(se0 + 1, "sum2_min");

    // Fill in IDLE: 4 accepted, 5th dropped
    tick();
    for (int i = 0; i < 5; i++) begin
      awe = 1'b1; bwe = 1'b1;
      a_in = (i < 4) ? 16'(i + 1) : 16'd9;
      b_in = 16'd1;
      tick();
      chk($sformatf("fill_aff_%0d", i), aff, (i >= 3) ? 1 : 0);
      chk($sformatf("fill_bff_%0d", i), bff, (i >= 3) ? 1 : 0);
    end
    awe = 1'b0; bwe = 1'b0;
    sbq.push_back('{16'd10, 1'b0, "drain_full"});
    se0 = se_cnt;
    pulse_start(8'd4);
    wait_se(se0 + 1, "drain_full");
    chk("drained_aff", aff, 0);
    sbq.push_back('{16'd25, 1'b0, "after_drop"});
    se0 = se_cnt;
    tick();
    pulse_start(8'd1);
    wr(16'd5, 16'd5);
    wait_se(se0 + 1, "after_drop");

    // Downstream stall holds consumption
    tick();
    wr(16'd2, 16'd3);
    ais = 1'b1;
    sbq.push_back('{16'd6, 1'b0, "stall_release"});
    se0 = se_cnt;
    pulse_start(8'd1);
    f0 = fout_cnt;
    repeat (4) tick();
    @(negedge clk);
    chk("stall_no_fout", fout_cnt - f0, 0);
    tick();
    ais = 1'b0;
    tick();
    @(negedge clk);
    chk("resume_fout", fout, 1);
    wait_se(se0 + 1, "stall_release");

    // Reset in the middle of RUN
    tick();
    pulse_start(8'd3);
    wr(16'd7, 16'd7);
    wr(16'd7, 16'd7);
    tick();
    @(negedge clk);
    chk("pre_rst_a_out", a_out, 7);
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_a_out", a_out, 0);
    chk("midrst_b_out", b_out, 0);
    chk("midrst_fout", fout, 0);
    chk("midrst_start_next", start_next, 0);
    chk("midrst_s_out", s_out, 0);
    tick();
    tick();
    chk("sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
